// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Runs entirely on clk_in. The divided pixel clock is sampled as data, and each
// rising edge becomes a one-cycle pixel tick that advances the (x,y) raster.
// Every output is registered from the next coordinates, so sync, blanking and
// start pulses always agree with the x/y values presented alongside them.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       pix_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Coordinates are 10 bits wide, so neither total may exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    // Last coordinate of each axis; reset parks the raster here so the first
    // tick wraps cleanly onto (0,0).
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region boundaries, one bit wider than the coordinates so that a sync
    // pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        pix_d;
    logic        tick;
    logic [9:0]  nx;
    logic [9:0]  ny;
    logic [10:0] nx_w;
    logic [10:0] ny_w;

    // pix_clk is already a clk_in-domain register output, so a plain
    // one-register edge detector is enough; no synchroniser is needed.
    assign tick = pix_clk & ~pix_d;

    assign nx_w = {1'b0, nx};
    assign ny_w = {1'b0, ny};

    // Next raster position: advance x on a tick, carry into y at end of line.
    always_comb begin
        nx = x;
        ny = y;
        if (tick) begin
            if (x == H_LAST) begin
                nx = '0;
                ny = (y == V_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                nx = x + 10'd1;
            end
        end
    end

    // Edge-detect register and one-cycle start pulses (low whenever no tick).
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pix_d       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_d       <= pix_clk;
            line_start  <= tick && (nx == 10'd0);
            frame_start <= tick && (nx == 10'd0) && (ny == 10'd0);
        end
    end

    // Raster position and timing outputs, updated only on pixel ticks so the
    // whole raster freezes while pix_clk is static.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            x        <= H_LAST;
            y        <= V_LAST;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b0;
        end else if (tick) begin
            x        <= nx;
            y        <= ny;
            video_on <= (nx_w < H_ACT_END) && (ny_w < V_ACT_END);
            hsync    <= ((nx_w >= H_SYNC_BEG) && (nx_w < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            vsync    <= ((ny_w >= V_SYNC_BEG) && (ny_w < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Instance A uses the default 640x480 timing, instance B a tiny 8x5 raster.
// The reference model counts pixel ticks since reset and derives the expected
// position and every output from that count with plain division/modulo.
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;
    logic pix_a  = 1'b0;
    logic pix_b  = 1'b0;

    always #5 clk_in = ~clk_in;

    logic       a_hsync, a_vsync, a_video_on, a_frame_start, a_line_start;
    logic [9:0] a_x, a_y;
    logic       b_hsync, b_vsync, b_video_on, b_frame_start, b_line_start;
    logic [9:0] b_x, b_y;

    vga_timing_gen dut_a (
        .clk_in     (clk_in),
        .rst        (rst_a),
        .pix_clk    (pix_a),
        .hsync      (a_hsync),
        .vsync      (a_vsync),
        .video_on   (a_video_on),
        .x          (a_x),
        .y          (a_y),
        .frame_start(a_frame_start),
        .line_start (a_line_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clk_in     (clk_in),
        .rst        (rst_b),
        .pix_clk    (pix_b),
        .hsync      (b_hsync),
        .vsync      (b_vsync),
        .video_on   (b_video_on),
        .x          (b_x),
        .y          (b_y),
        .frame_start(b_frame_start),
        .line_start (b_line_start)
    );

    // Observed bundle: {x, y, hsync, vsync, video_on, line_start, frame_start}
    logic [24:0] obs_a, obs_b;
    assign obs_a = {a_x, a_y, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start};
    assign obs_b = {b_x, b_y, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start};

    // ---------------- model state ----------------
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    longint cnt_a    = 0;
    longint cnt_b    = 0;
    logic   last_a   = 1'b0;
    logic   last_b   = 1'b0;
    logic   tk_a     = 1'b0;
    logic   tk_b     = 1'b0;
    logic   ph_a     = 1'b0;
    logic   ph_b     = 1'b0;

    // Expected outputs after cnt ticks since reset (cnt == 0: reset state).
    // Sync polarity is active-low in both instances.
    function automatic logic [24:0] model_out(input longint cnt, input logic tk,
                                              input int ha, input int hf, input int hs, input int hb,
                                              input int va, input int vf, input int vs, input int vb);
        int   ht, vt, p, ex, ey;
        logic vid, hsy, vsy, ls, fs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (cnt == 0)
            return {10'(ht - 1), 10'(vt - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        p   = int'((cnt - 1) % longint'(ht * vt));
        ex  = p % ht;
        ey  = p / ht;
        vid = (ex < ha) && (ey < va);
        hsy = !((ex >= ha + hf) && (ex < ha + hf + hs));
        vsy = !((ey >= va + vf) && (ey < va + vf + vs));
        ls  = tk && (ex == 0);
        fs  = ls && (ey == 0);
        return {10'(ex), 10'(ey), hsy, vsy, vid, ls, fs};
    endfunction

    function automatic logic [24:0] exp_a();
        return model_out(cnt_a, tk_a, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] exp_b();
        return model_out(cnt_b, tk_b, 4, 1, 2, 1, 2, 1, 1, 1);
    endfunction

    // ---------------- driver ----------------
    // Drive both pixel clocks at the falling edge, account for the tick the
    // DUT will see at the next rising edge, then return 1 time unit after it.
    task automatic cycle(input logic va, input logic vb);
        @(negedge clk_in);
        pix_a = va;
        pix_b = vb;
        if (rst_a) begin
            cnt_a = 0; last_a = 1'b0; tk_a = 1'b0;
        end else begin
            tk_a = va && !last_a;
            if (tk_a) cnt_a++;
            last_a = va;
        end
        if (rst_b) begin
            cnt_b = 0; last_b = 1'b0; tk_b = 1'b0;
        end else begin
            tk_b = vb && !last_b;
            if (tk_b) cnt_b++;
            last_b = vb;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(i[0], ~i[0]);
            n_checks++;
            if (obs_a !== {10'd799, 10'd524, 5'b11000}) begin
                n_fail++;
                $display("FAIL reset_a: got %h expected %h", obs_a, {10'd799, 10'd524, 5'b11000});
            end
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL reset_b: got %h expected %h", obs_b, exp_b());
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        cycle(1'b1, 1'b1);
        n_checks++;
        if ({a_x, a_y, a_video_on, a_line_start, a_frame_start} !== {10'd0, 10'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL first_tick_a: got %h expected %h",
                     {a_x, a_y, a_video_on, a_line_start, a_frame_start}, {10'd0, 10'd0, 3'b111});
        end
        n_checks++;
        if (obs_b !== exp_b()) begin
            n_fail++;
            $display("FAIL first_tick_b: got %h expected %h", obs_b, exp_b());
        end
        cycle(1'b0, 1'b0);
        n_checks++;
        if ({a_x, a_y, a_line_start, a_frame_start} !== {10'd0, 10'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL pulse_width_a: got %h expected %h",
                     {a_x, a_y, a_line_start, a_frame_start}, {10'd0, 10'd0, 2'b00});
        end
    endtask

    task automatic test_line();
        int   hs_cycles = 0;
        int   hs_min    = 1023;
        int   hs_max    = 0;
        int   first_off = -1;
        logic saw_wrap  = 1'b0;
        ph_a = last_a;
        for (int i = 0; i < 3300; i++) begin
            ph_a = ~ph_a;
            cycle(ph_a, 1'b0);
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL line_model cyc=%0d: got %h expected %h", cyc, obs_a, exp_a());
            end
            if (a_y == 10'd0 && a_hsync == 1'b0) begin
                hs_cycles++;
                if (int'(a_x) < hs_min) hs_min = int'(a_x);
                if (int'(a_x) > hs_max) hs_max = int'(a_x);
            end
            if (a_y == 10'd0 && !a_video_on && first_off < 0) first_off = int'(a_x);
            if (a_line_start && a_y == 10'd1 && a_x == 10'd0) saw_wrap = 1'b1;
        end
        n_checks++;
        if (hs_cycles != 192) begin
            n_fail++;
            $display("FAIL hsync_cycles: got %0d expected 192", hs_cycles);
        end
        n_checks++;
        if (hs_min != 656 || hs_max != 751) begin
            n_fail++;
            $display("FAIL hsync_range: got %0d..%0d expected 656..751", hs_min, hs_max);
        end
        n_checks++;
        if (first_off != 640) begin
            n_fail++;
            $display("FAIL video_off_x: got %0d expected 640", first_off);
        end
        n_checks++;
        if (saw_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL line_wrap: got %b expected 1", saw_wrap);
        end
    endtask

    task automatic test_freeze();
        int hold0;
        ph_a = last_a;
        for (int i = 0; i < 4000 && a_x != 10'd300; i++) begin
            ph_a = ~ph_a;
            cycle(ph_a, 1'b0);
        end
        n_checks++;
        if (a_x !== 10'd300) begin
            n_fail++;
            $display("FAIL reach_x300: got %0d expected 300", a_x);
        end
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0);
            n_checks++;
            if ({a_x, a_line_start, a_frame_start} !== {10'd300, 2'b00} || obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL freeze_high i=%0d: got %h expected %h", i, obs_a, exp_a());
            end
        end
        hold0 = int'($urandom_range(3, 20));
        for (int i = 0; i < hold0; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({a_x, a_line_start, a_frame_start} !== {10'd300, 2'b00} || obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL freeze_low i=%0d: got %h expected %h", i, obs_a, exp_a());
            end
        end
        cycle(1'b1, 1'b0);
        n_checks++;
        if (a_x !== 10'd301 || obs_a !== exp_a()) begin
            n_fail++;
            $display("FAIL resume: got x=%0d expected x=301", a_x);
        end
    endtask

    task automatic test_async_reset();
        ph_a = last_a;
        for (int i = 0; i < 4000 && a_x != 10'd700; i++) begin
            ph_a = ~ph_a;
            cycle(ph_a, 1'b0);
        end
        n_checks++;
        if (a_x !== 10'd700) begin
            n_fail++;
            $display("FAIL reach_x700: got %0d expected 700", a_x);
        end
        #($urandom_range(1, 2));
        rst_a = 1'b1;
        cnt_a = 0; last_a = 1'b0; tk_a = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== {10'd799, 10'd524, 5'b11000}) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs_a, {10'd799, 10'd524, 5'b11000});
        end
        for (int j = 0; j < 3; j++) begin
            cycle((j == 2) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL reset_hold j=%0d: got %h expected %h", j, obs_a, exp_a());
            end
        end
        rst_a = 1'b0;
        cycle(1'b1, 1'b0);
        n_checks++;
        if ({a_x, a_y, a_video_on, a_line_start, a_frame_start} !== {10'd0, 10'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL restart_high_pix: got %h expected %h",
                     {a_x, a_y, a_video_on, a_line_start, a_frame_start}, {10'd0, 10'd0, 3'b111});
        end
    endtask

    task automatic test_frame();
        logic [31:0] exp_q[$];
        logic [31:0] want;
        logic [9:0]  px, py;
        int vs_cycles = 0;
        int bad_vs    = 0;
        int bad_vid   = 0;
        int frames    = 0;
        ph_b = last_b;
        px   = b_x;
        py   = b_y;
        for (int i = 0; i < 260; i++) begin
            ph_b = ~ph_b;
            cycle(1'b0, ph_b);
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL frame_model cyc=%0d: got %h expected %h", cyc, obs_b, exp_b());
            end
            if (!b_vsync) begin
                if (frames == 1) vs_cycles++;
                if (b_y != 10'd3) bad_vs++;
            end
            if (b_video_on && b_y >= 10'd2) bad_vid++;
            if (b_frame_start) begin
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    n_checks++;
                    if (32'(cyc) !== want) begin
                        n_fail++;
                        $display("FAIL frame_period: got cycle %0d expected %0d", cyc, want);
                    end
                end
                n_checks++;
                if ({px, py} !== {10'd7, 10'd4}) begin
                    n_fail++;
                    $display("FAIL frame_wrap_from: got (%0d,%0d) expected (7,4)", px, py);
                end
                exp_q.push_back(32'(cyc + 80));
                frames++;
            end
            px = b_x;
            py = b_y;
        end
        n_checks++;
        if (frames != 3) begin
            n_fail++;
            $display("FAIL frame_count: got %0d expected 3", frames);
        end
        n_checks++;
        if (vs_cycles != 16 || bad_vs != 0) begin
            n_fail++;
            $display("FAIL vsync_window: got %0d cycles, %0d outside y=3; expected 16, 0", vs_cycles, bad_vs);
        end
        n_checks++;
        if (bad_vid != 0) begin
            n_fail++;
            $display("FAIL video_on_vblank: got %0d active cycles expected 0", bad_vid);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL rand_a cyc=%0d: got %h expected %h", cyc, obs_a, exp_a());
            end
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL rand_b cyc=%0d: got %h expected %h", cyc, obs_b, exp_b());
            end
            if ($urandom_range(0, 149) == 0) begin
                #($urandom_range(1, 2));
                if ($urandom_range(0, 1) == 1) begin
                    rst_a = 1'b1; cnt_a = 0; last_a = 1'b0; tk_a = 1'b0;
                end else begin
                    rst_b = 1'b1; cnt_b = 0; last_b = 1'b0; tk_b = 1'b0;
                end
                #1;
                n_checks++;
                if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                    n_fail++;
                    $display("FAIL rand_async_rst cyc=%0d: got %h/%h expected %h/%h",
                             cyc, obs_a, obs_b, exp_a(), exp_b());
                end
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) begin
                    cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    n_checks++;
                    if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                        n_fail++;
                        $display("FAIL rand_rst_hold cyc=%0d: got %h/%h expected %h/%h",
                                 cyc, obs_a, obs_b, exp_a(), exp_b());
                    end
                end
                rst_a = 1'b0;
                rst_b = 1'b0;
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_line();
        test_freeze();
        test_async_reset();
        test_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
